// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Slave end of the CPU memory interface. Accepts one load/store
//             at a time, waits LATENCY cycles, then commits the access and
//             pulses a response. Performs RV32I byte/half/word decoding with
//             sign/zero extension on loads and lane merging on stores.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH_WORDS : number of 32-bit words of storage (power of two)
//    LATENCY     : wait-state cycles between accept and commit (0..15)
//  Optional build macro
//    MEM_MISALIGN_TRAP_EN : misaligned half/word accesses respond with an
//                           error instead of being forced to alignment
//  Ports
//    clk        in   clock, rising edge
//    rst        in   asynchronous active-low reset
//    req_valid  in   request present
//    req_ready  out  responder idle and able to accept
//    req_we     in   1 = store, 0 = load
//    req_func3  in   RV32I funct3 of the access
//    req_addr   in   byte address
//    req_wdata  in   store data, right-aligned
//    rsp_valid  out  one-cycle response pulse
//    rsp_rdata  out  extended load result (0 for stores / errors)
//    rsp_err    out  illegal funct3 or trapped misalignment
//    busy       out  high while a request is outstanding
// ============================================================================
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LATENCY_W  = 4'(LATENCY);
    localparam bit         ZERO_WAIT  = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    logic        lat_we;
    logic [2:0]  lat_func3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the commit happens on the accept edge itself, so
    // the access is decoded straight from the request inputs.
    logic        acc_we;
    logic [2:0]  acc_func3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    assign acc_we    = ZERO_WAIT ? req_we    : lat_we;
    assign acc_func3 = ZERO_WAIT ? req_func3 : lat_func3;
    assign acc_addr  = ZERO_WAIT ? req_addr  : lat_addr;
    assign acc_wdata = ZERO_WAIT ? req_wdata : lat_wdata;

    assign req_ready = (state == IDLE) && rst;
    assign busy      = (state != IDLE);

    logic handshake;
    logic commit;

    assign handshake = req_valid && req_ready;
    assign commit    = ZERO_WAIT ? handshake
                                 : (rst && (state == WAIT) && (wait_cnt == 4'd1));

    // Upper address bits only select aliases of the same word.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[31:AW+2];

    logic [AW-1:0] word_idx;
    logic          size_half;
    logic          size_word;
    logic          illegal;
    logic          access_err;
    logic [1:0]    lane;
    logic [31:0]   old_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   aligned_wdata;
    logic [31:0]   merged_word;

    assign word_idx = acc_addr[AW+1:2];

    always_comb begin
        size_half = (acc_func3[1:0] == 2'b01);
        size_word = (acc_func3[1:0] == 2'b10);
        // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
        illegal   = acc_we ? (acc_func3 > 3'd2)
                           : ((acc_func3 == 3'b011) || (acc_func3[2:1] == 2'b11));
`ifdef MEM_MISALIGN_TRAP_EN
        access_err = illegal
                   || (size_half && acc_addr[0])
                   || (size_word && (acc_addr[1:0] != 2'b00));
        lane       = acc_addr[1:0];
`else
        access_err = illegal;
        lane       = size_word ? 2'b00 :
                     size_half ? {acc_addr[1], 1'b0} : acc_addr[1:0];
`endif
        old_word = mem[word_idx];
        shifted  = old_word >> {lane, 3'b000};
        case (acc_func3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
        byte_en       = size_word ? 4'b1111 :
                        size_half ? (4'b0011 << lane) : (4'b0001 << lane);
        aligned_wdata = acc_wdata << {lane, 3'b000};
        merged_word   = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged_word[8*b +: 8] = aligned_wdata[8*b +: 8];
            end
        end
    end

    // Storage is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !access_err) begin
            mem[word_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_func3 <= 3'd0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        lat_we    <= req_we;
                        lat_func3 <= req_func3;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (ZERO_WAIT) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= LATENCY_W;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Response data is captured from the pre-write array contents.
            if (commit) begin
                rsp_rdata <= (acc_we || access_err) ? 32'h0 : load_data;
                rsp_err   <= access_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. Two instances (LATENCY=2
//             and LATENCY=0) are driven by directed and random accesses; a
//             byte-addressed reference memory predicts every response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [2:0]  req_func3 [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;
    logic [1:0]  busy;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_func3(req_func3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_func3(req_func3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          dut;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        expq [$];
    logic [7:0]  mm [2][DEPTH*4];
    logic [31:0] last_rd  [2];
    logic        last_err [2];

    function automatic int lat_of(input int s);
        return (s == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: byte-addressed memory, accesses described by size/signedness.
    function automatic void model_access(input int s, input logic we, input logic [2:0] f,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int         size;
        bit         sgn;
        bit         legal;
        int         off;
        int         base;
        logic [63:0] v;
        legal = 1; sgn = 0; size = 1;
        rd = 32'h0; err = 1'b0;
        case (f)
            3'd0:    begin size = 1; sgn = 1; end
            3'd1:    begin size = 2; sgn = 1; end
            3'd2:    begin size = 4; end
            3'd4:    begin size = 1; legal = !we; end
            3'd5:    begin size = 2; legal = !we; end
            default: legal = 0;
        endcase
        if (!legal) begin
            err = 1'b1;
            return;
        end
        off = int'(a[1:0]);
        if ((off % size) != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
            err = 1'b1;
            return;
`else
            off = off - (off % size);
`endif
        end
        base = int'((a / 4) % DEPTH) * 4;
        if (we) begin
            for (int i = 0; i < size; i++) mm[s][base + off + i] = wd[8*i +: 8];
        end else begin
            v = 64'h0;
            for (int i = 0; i < size; i++) v = v | (64'(mm[s][base + off + i]) << (8 * i));
            if (sgn && v[8*size-1]) v = v | (~64'h0 << (8 * size));
            rd = v[31:0];
        end
    endfunction

    // Output checker: every cycle, for both instances.
    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (!rst) begin
                chk("reset_rsp_valid", 32'(rsp_valid[s]), 32'h0);
                chk("reset_rsp_rdata", rsp_rdata[s], 32'h0);
                chk("reset_rsp_err", 32'(rsp_err[s]), 32'h0);
                chk("reset_busy", 32'(busy[s]), 32'h0);
                chk("reset_req_ready", 32'(req_ready[s]), 32'h0);
                last_rd[s]  = 32'h0;
                last_err[s] = 1'b0;
            end else if (rsp_valid[s]) begin
                if (expq.size() == 0 || expq[0].dut != s) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid[s]), 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_rdata", rsp_rdata[s], e.rd);
                    chk("rsp_err", 32'(rsp_err[s]), 32'(e.err));
                    chk("rsp_busy", 32'(busy[s]), 32'h1);
                end
                last_rd[s]  = rsp_rdata[s];
                last_err[s] = rsp_err[s];
            end else begin
                chk("hold_rdata", rsp_rdata[s], last_rd[s]);
                chk("hold_err", 32'(rsp_err[s]), 32'(last_err[s]));
            end
        end
    end

    task automatic op(input int s, input logic we, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit lit = 0, input logic [31:0] lit_rd = 0, input logic lit_err = 0);
        logic [31:0] mrd;
        logic        merr;
        int          n;
        int          lowc;
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_func3[s] = f;
        req_addr[s]  = a;
        req_wdata[s] = wd;
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[s]) begin
            chk("accept_timeout", 32'(req_ready[s]), 32'h1);
            req_valid[s] = 1'b0;
            return;
        end
        model_access(s, we, f, a, wd, mrd, merr);
        if (lit) begin
            chk("model_rd", mrd, lit_rd);
            chk("model_err", 32'(merr), 32'(lit_err));
        end
        expq.push_back('{dut: s, rd: mrd, err: merr, cyc: cyc + 1 + lat_of(s)});
        @(negedge clk);
        // Garbage requests while busy must be ignored.
        lowc = 0;
        while (!req_ready[s] && lowc < 50) begin
            chk("busy_while_wait", 32'(busy[s]), 32'h1);
            req_valid[s] = 1'b1;
            req_we[s]    = 1'($urandom);
            req_func3[s] = 3'($urandom);
            req_addr[s]  = $urandom;
            req_wdata[s] = $urandom;
            lowc++;
            @(negedge clk);
        end
        req_valid[s] = 1'b0;
        chk("ready_low_cycles", lowc, lat_of(s) + 1);
        chk("rsp_outstanding", expq.size(), 32'h0);
        expq.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_func3[s] = 3'd0;
            req_addr[s] = 32'h0; req_wdata[s] = 32'h0;
            last_rd[s] = 32'h0; last_err[s] = 1'b0;
        end
        #1 rst = 1'b0;
        #2;
        chk("init_req_ready", 32'(req_ready[0]), 32'h0);
        chk("init_busy", 32'(busy[0]), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready[0]), 32'h1);
        chk("post_reset_rdata", rsp_rdata[0], 32'h0);

        // Give every word a known value in both instances.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++)
                op(s, 1'b1, 3'd2, 32'(w * 4), $urandom);

        // Directed sequence on the LATENCY=2 instance.
        op(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
        op(0, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
        op(0, 1, 3'd0, 32'h11, 32'h80, 1, 32'h0, 0);
        op(0, 0, 3'd0, 32'h11, 32'h0, 1, 32'hFFFFFF80, 0);
        op(0, 0, 3'd4, 32'h11, 32'h0, 1, 32'h00000080, 0);
        op(0, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0);
        op(0, 0, 3'd1, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 0);
        op(0, 0, 3'd5, 32'h12, 32'h0, 1, 32'h0000DEAD, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        op(0, 0, 3'd2, 32'h13, 32'h0, 1, 32'h0, 1);
`else
        op(0, 0, 3'd2, 32'h13, 32'h0, 1, 32'hDEAD80EF, 0);
`endif
        op(0, 1, 3'd2, 32'h1000, 32'h12345678, 1, 32'h0, 0);
        op(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'h12345678, 0);
        op(0, 0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 1);
        op(0, 1, 3'd4, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1);
        op(0, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0);
        op(0, 1, 3'd2, 32'h20, 32'h0BADF00D, 1, 32'h0, 0);

        // Reset in the middle of WAIT: request must vanish without a write.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_func3[0] = 3'd2;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h55;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("wait_busy", 32'(busy[0]), 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_ready", 32'(req_ready[0]), 32'h0);
        chk("async_reset_busy", 32'(busy[0]), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) @(negedge clk);
        op(0, 0, 3'd2, 32'h20, 32'h0, 1, 32'h0BADF00D, 0);

        // LATENCY=0 instance.
        op(1, 1, 3'd2, 32'h40, 32'hCAFEF00D, 1, 32'h0, 0);
        op(1, 0, 3'd2, 32'h40, 32'h0, 1, 32'hCAFEF00D, 0);
        op(1, 1, 3'd0, 32'h43, 32'h7F, 1, 32'h0, 0);
        op(1, 0, 3'd0, 32'h43, 32'h0, 1, 32'h0000007F, 0);
        op(1, 0, 3'd5, 32'h42, 32'h0, 1, 32'h00007FFE, 0);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            op(k % 2, 1'($urandom), 3'($urandom), $urandom, $urandom);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
